// File: rtl/key_code_gen.sv
// Two debounced keys drive a 3-bit code for a 3-8 decoder.
// key_step advances the code; key_mode toggles timed auto-step.
module key_code_gen #(
  parameter logic [19:0] CNT_MAX  = 20'd999_999,
  parameter logic [24:0] STEP_MAX = 25'd24_999_999
) (
  input  logic sys_clk,
  input  logic sys_rst_n,
  input  logic key_step,
  input  logic key_mode,
  output logic in1,
  output logic in2,
  output logic in3,
  output logic auto_en,
  output logic code_vld
);

  localparam int STEP = 0;
  localparam int MODE = 1;

  logic [1:0]  key_raw;
  logic [1:0]  sync1_q;
  logic [1:0]  sync2_q;
  logic [19:0] dcnt_q [2];
  logic [19:0] dcnt_d [2];
  logic [1:0]  press_q;
  logic [1:0]  press_d;

  logic [2:0]  code_q;
  logic [2:0]  code_d;
  logic        auto_q;
  logic        auto_d;
  logic        vld_q;
  logic        vld_d;
  logic [24:0] scnt_q;
  logic [24:0] scnt_d;
  logic        wrap;
  logic        inc;

  assign key_raw = {key_mode, key_step};

  // Synchronisers, debounce counters and registered press pulses
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
      press_q <= 2'b00;
      for (int i = 0; i < 2; i++) begin
        dcnt_q[i] <= '0;
      end
    end else begin
      sync1_q <= key_raw;
      sync2_q <= sync1_q;
      press_q <= press_d;
      for (int i = 0; i < 2; i++) begin
        dcnt_q[i] <= dcnt_d[i];
      end
    end
  end

  // Count low time; fire once when the count is about to saturate
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      dcnt_d[i]  = dcnt_q[i];
      press_d[i] = 1'b0;
      if (sync2_q[i]) begin
        dcnt_d[i] = '0;
      end else begin
        if (dcnt_q[i] != CNT_MAX) begin
          dcnt_d[i] = dcnt_q[i] + 20'd1;
        end
        press_d[i] = (dcnt_q[i] == CNT_MAX - 20'd1);
      end
    end
  end

  // Code, mode, strobe and auto-step counter state
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      code_q <= 3'd0;
      auto_q <= 1'b0;
      vld_q  <= 1'b0;
      scnt_q <= '0;
    end else begin
      code_q <= code_d;
      auto_q <= auto_d;
      vld_q  <= vld_d;
      scnt_q <= scnt_d;
    end
  end

  // A step press and an auto wrap merge into a single increment
  always_comb begin
    wrap   = auto_q && (scnt_q == STEP_MAX);
    inc    = press_q[STEP] || wrap;
    code_d = code_q;
    vld_d  = inc;
    auto_d = auto_q ^ press_q[MODE];
    scnt_d = scnt_q + 25'd1;
    if (inc) begin
      code_d = code_q + 3'd1;
    end
    if (press_q[MODE] || !auto_q || inc) begin
      scnt_d = '0;
    end
  end

  assign in1      = code_q[2];
  assign in2      = code_q[1];
  assign in3      = code_q[0];
  assign auto_en  = auto_q;
  assign code_vld = vld_q;

endmodule

// File: tb/tb_key_code_gen.sv
// Bench for key_code_gen: run-length key model plus
// directed timing checks with CNT_MAX=4, STEP_MAX=7.
module tb_key_code_gen;

  localparam int CNT  = 4;
  localparam int STEP = 7;

  logic sys_clk   = 1'b0;
  logic sys_rst_n = 1'b1;
  logic key_step  = 1'b1;
  logic key_mode  = 1'b1;
  logic in1, in2, in3, auto_en, code_vld;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;
  int cyc = 0;
  int vld_cnt = 0;

  key_code_gen #(
    .CNT_MAX (20'd4),
    .STEP_MAX(25'd7)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .key_step (key_step),
    .key_mode (key_mode),
    .in1      (in1),
    .in2      (in2),
    .in3      (in3),
    .auto_en  (auto_en),
    .code_vld (code_vld)
  );

  always #5 sys_clk = ~sys_clk;

  always @(posedge sys_clk) cyc <= cyc + 1;

  always @(negedge sys_clk) if (code_vld === 1'b1) vld_cnt++;

  function automatic logic [2:0] cur_code();
    return {in1, in2, in3};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Model: a press is confirmed when a key has been sampled low
  // for CNT consecutive edges; the code moves three edges later.
  int m_code = 0;
  bit m_auto = 1'b0;
  bit m_vld  = 1'b0;
  int s_run  = 0;
  int m_run  = 0;
  int s_h [3] = '{0, 0, 0};
  int m_h [3] = '{0, 0, 0};
  int since  = 0;
  bit sp, mp, wr;

  always @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      m_code = 0;
      m_auto = 1'b0;
      m_vld  = 1'b0;
      s_run  = 0;
      m_run  = 0;
      s_h    = '{0, 0, 0};
      m_h    = '{0, 0, 0};
      since  = 0;
    end else begin
      sp = (s_h[2] == CNT);
      mp = (m_h[2] == CNT);
      s_h[2] = s_h[1];
      s_h[1] = s_h[0];
      m_h[2] = m_h[1];
      m_h[1] = m_h[0];
      s_run = key_step ? 0 : (s_run > CNT ? s_run : s_run + 1);
      m_run = key_mode ? 0 : (m_run > CNT ? m_run : m_run + 1);
      s_h[0] = s_run;
      m_h[0] = m_run;
      since++;
      wr = m_auto && (since == STEP + 1);
      m_vld = sp || wr;
      if (m_vld) m_code = (m_code + 1) % 8;
      if (mp) m_auto = !m_auto;
      if (mp || m_vld) since = 0;
    end
  end

  always @(negedge sys_clk) begin
    if (chk_en) begin
      chk("model_code", cur_code(), m_code);
      chk("model_auto", auto_en, m_auto);
      chk("model_vld", code_vld, m_vld);
    end
  end

  task automatic hold_key(input bit mode, input int n);
    @(negedge sys_clk);
    if (mode) key_mode = 1'b0;
    else key_step = 1'b0;
    repeat (n) @(negedge sys_clk);
    key_mode = 1'b1;
    key_step = 1'b1;
    repeat (8) @(negedge sys_clk);
  endtask

  int c0, cprev, e_on, w, v0, f;

  initial begin
    #3 sys_rst_n = 1'b0;
    #1 chk_en = 1'b1;
    chk("rst_code0", cur_code(), 0);
    for (int i = 0; i < 6; i++) begin
      #3;
      key_step = ~key_step;
      key_mode = ~key_mode;
      #1;
      chk("rst_code", cur_code(), 0);
      chk("rst_auto", auto_en, 0);
      chk("rst_vld", code_vld, 0);
    end
    @(negedge sys_clk);
    key_step = 1'b1;
    key_mode = 1'b1;
    sys_rst_n = 1'b1;
    repeat (3) @(negedge sys_clk);

    @(negedge sys_clk);
    key_step = 1'b0;
    @(posedge sys_clk);
    repeat (5) @(posedge sys_clk);
    #1 chk("lat_n5", cur_code(), 0);
    @(posedge sys_clk);
    #1 chk("lat_n6", cur_code(), 1);
    chk("lat_vld", code_vld, 1);
    @(posedge sys_clk);
    #1 chk("vld_one_cycle", code_vld, 0);
    repeat (12) @(negedge sys_clk);
    key_step = 1'b1;
    repeat (8) @(negedge sys_clk);
    chk("hold_once", cur_code(), 1);

    for (int i = 0; i < 7; i++) hold_key(1'b0, 20);
    chk("wrap_after_8", cur_code(), 0);

    v0 = vld_cnt;
    c0 = cur_code();
    @(negedge sys_clk);
    for (int i = 0; i < 5; i++) begin
      key_step = 1'b0;
      repeat (3) @(negedge sys_clk);
      key_step = 1'b1;
      @(negedge sys_clk);
    end
    repeat (8) @(negedge sys_clk);
    chk("bounce_code", cur_code(), c0);
    chk("bounce_vld", vld_cnt - v0, 0);

    @(negedge sys_clk);
    key_mode = 1'b0;
    @(posedge sys_clk);
    repeat (5) @(posedge sys_clk);
    #1 chk("auto_n5", auto_en, 0);
    @(posedge sys_clk);
    #1 chk("auto_on", auto_en, 1);
    e_on = cyc;
    c0 = cur_code();
    repeat (7) @(posedge sys_clk);
    #1 chk("auto_hold7", cur_code(), c0);
    @(posedge sys_clk);
    #1 chk("auto_step8", cur_code(), (c0 + 1) % 8);
    @(negedge sys_clk);
    key_mode = 1'b1;
    repeat (64) @(negedge sys_clk);

    w = e_on + 8 * ((cyc + 16 - e_on) / 8 + 1);
    for (int i = 0; i < 200 && cyc < w - 7; i++) @(negedge sys_clk);
    chk("coinc_align", cyc, w - 7);
    key_step = 1'b0;
    repeat (6) @(posedge sys_clk);
    #1 cprev = cur_code();
    @(posedge sys_clk);
    #1 chk("coinc_inc", cur_code(), (cprev + 1) % 8);
    chk("coinc_vld", code_vld, 1);
    repeat (7) @(posedge sys_clk);
    #1 chk("coinc_hold", cur_code(), (cprev + 1) % 8);
    @(posedge sys_clk);
    #1 chk("coinc_next", cur_code(), (cprev + 2) % 8);
    @(negedge sys_clk);
    key_step = 1'b1;

    hold_key(1'b1, 10);
    chk("auto_off", auto_en, 0);
    f = cur_code();
    repeat (30) @(negedge sys_clk);
    chk("freeze", cur_code(), f);

    hold_key(1'b1, 10);
    chk("auto_again", auto_en, 1);
    for (int i = 0; i < 200 && cur_code() != 3'd5; i++)
      @(negedge sys_clk);
    chk("reach_101", cur_code(), 5);
    key_step = 1'b0;
    repeat (2) @(negedge sys_clk);
    #2 sys_rst_n = 1'b0;
    #1 chk("mid_rst_code", cur_code(), 0);
    chk("mid_rst_auto", auto_en, 0);
    chk("mid_rst_vld", code_vld, 0);
    repeat (3) @(negedge sys_clk);
    sys_rst_n = 1'b1;
    @(posedge sys_clk);
    repeat (5) @(posedge sys_clk);
    #1 chk("post_rst_n5", cur_code(), 0);
    @(posedge sys_clk);
    #1 chk("post_rst_n6", cur_code(), 1);
    repeat (10) @(negedge sys_clk);
    chk("post_rst_once", cur_code(), 1);
    chk("post_rst_auto", auto_en, 0);
    key_step = 1'b1;
    repeat (8) @(negedge sys_clk);

    chk_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
